// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Build option: define DMEM_ARB_RR_EN for round-robin IDLE contention (default: p0 priority).
package dmem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/dmem_arb_pick.sv
// IDLE-state winner selection: the port that was not granted last wins contention.
// The fixed-priority build (DMEM_ARB_RR_EN undefined) feeds a constant PORT1 so p0 always wins.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic     p0_req_i,
    input  logic     p1_req_i,
    input  port_id_t last_i,
    output logic     p0_win_o,
    output logic     p1_win_o
);

    always_comb begin
        p0_win_o = p0_req_i & (~p1_req_i | (last_i == PORT1));
        p1_win_o = p1_req_i & (~p0_req_i | (last_i == PORT0));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (p0) vs debug/loader (p1) with bounded p1 lock bursts.
// Build option: define DMEM_ARB_RR_EN for round-robin IDLE contention (default: p0 priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              core_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvalid_q;
    port_id_t         owner_q;
    port_id_t         rr_last;
    logic             pick0, pick1;
    logic             read_fire;

`ifdef DMEM_ARB_RR_EN
    port_id_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (p1_gnt)      last_d = PORT1;
        else if (p0_gnt) last_d = PORT0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= PORT1;
        else        last_q <= last_d;
    end

    assign rr_last = last_q;
`else
    assign rr_last = PORT1;
`endif

    dmem_arb_pick u_pick (
        .p0_req_i (p0_req),
        .p1_req_i (p1_req),
        .last_i   (rr_last),
        .p0_win_o (pick0),
        .p1_win_o (pick1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p0_gnt  = 1'b0;
        p1_gnt  = 1'b0;
        case (state_q)
            IDLE: begin
                p0_gnt = pick0;
                p1_gnt = pick1;
                if (pick1 && p1_lock) begin
                    state_d = LOCK1;
                    cnt_d   = CNT_W'(1);
                end
            end
            LOCK1: begin
                if (!p1_req || !p1_lock) begin
                    // Lock released: this cycle is arbitrated exactly as in IDLE.
                    state_d = IDLE;
                    cnt_d   = '0;
                    p0_gnt  = pick0;
                    p1_gnt  = pick1;
                end else if (cnt_q == CNT_MAX && p0_req) begin
                    p0_gnt = 1'b1;
                    cnt_d  = '0;
                end else begin
                    p1_gnt = 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    assign mem_en     = p0_gnt | p1_gnt;
    assign read_fire  = mem_en & ~mem_we;
    assign core_stall = p0_req & ~p0_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= PORT0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= read_fire;
            if (read_fire) owner_q <= p1_gnt;
        end
    end

    // A single valid bit plus owner steers the returning word to exactly one port.
    assign p0_rvalid = rvalid_q & (owner_q == PORT0);
    assign p1_rvalid = rvalid_q & (owner_q == PORT1);
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; honours DMEM_ARB_RR_EN for contention expectations.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [8:0]  p0_addr, p1_addr, mem_addr;
    logic [31:0] p0_wdata, p1_wdata, mem_wdata, mem_rdata, rdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, core_stall, mem_en, mem_we;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .core_stall(core_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory with fixed contents; writes are checked on the mem_* bus only.
    function automatic logic [31:0] mem_word(input logic [8:0] a);
        case (a)
            9'd1:    return 32'h0000_0011;
            9'd2:    return 32'h0000_0022;
            9'd5:    return 32'h0000_00AA;
            default: return {23'd0, a};
        endcase
    endfunction

    always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= mem_word(mem_addr);

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (p0_rvalid || p1_rvalid) begin
            check("rvalid_onehot", 32'(p0_rvalid & p1_rvalid), 32'd0);
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rvalid_port", 32'(p1_rvalid), 32'(e.port));
                check("rdata", rdata, e.data);
                check("rvalid_latency", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            check("rvalid_missing", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic drive(input string nm,
                         input logic a_req, input logic a_we, input logic [8:0] a_addr, input logic [31:0] a_wd,
                         input logic b_req, input logic b_we, input logic b_lock, input logic [8:0] b_addr,
                         input logic [31:0] b_wd,
                         input logic e_g0, input logic e_g1, input logic [31:0] e_rd);
        exp_t e;
        @(negedge clk);
        p0_req = a_req; p0_we = a_we; p0_addr = a_addr; p0_wdata = a_wd;
        p1_req = b_req; p1_we = b_we; p1_lock = b_lock; p1_addr = b_addr; p1_wdata = b_wd;
        #2;
        check({nm, ".p0_gnt"}, 32'(p0_gnt), 32'(e_g0));
        check({nm, ".p1_gnt"}, 32'(p1_gnt), 32'(e_g1));
        check({nm, ".core_stall"}, 32'(core_stall), 32'(a_req & ~e_g0));
        check({nm, ".mem_en"}, 32'(mem_en), 32'(e_g0 | e_g1));
        check({nm, ".mem_addr"}, 32'(mem_addr), e_g0 ? 32'(a_addr) : (e_g1 ? 32'(b_addr) : 32'd0));
        check({nm, ".mem_we"}, 32'(mem_we), e_g0 ? 32'(a_we) : (e_g1 ? 32'(b_we) : 32'd0));
        if (e_g0 | e_g1)
            check({nm, ".mem_wdata"}, mem_wdata, e_g0 ? a_wd : b_wd);
        if (reset && ((e_g0 && !a_we) || (e_g1 && !b_we))) begin
            e.port = e_g1;
            e.data = e_rd;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        mem_rdata = '0;

        // Reset state and combinational follow-through from IDLE.
        @(negedge clk);
        #2;
        check("rst.p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("rst.p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rst.mem_en", 32'(mem_en), 32'd0);
        p0_req = 1'b1; p1_req = 1'b1; p1_lock = 1'b1;
        #1;
        check("rst.p0_gnt", 32'(p0_gnt), 32'd1);
        check("rst.p1_gnt", 32'(p1_gnt), 32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;

        // Single p0 read of word 5.
        drive("rd5", 1, 0, 9'd5, 0, 0, 0, 0, 9'd0, 0, 1, 0, 32'hAA);
        drive("idle0", 0, 0, 9'd0, 0, 0, 0, 0, 9'd0, 0, 0, 0, 0);

        // Continuous contention, unlocked writes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            drive("cont", 1, 1, 9'd8, 32'h80 + i, 1, 1, 0, 9'd9, 32'h90 + i, (i % 2) == 0, (i % 2) == 1, 0);
`else
            drive("cont", 1, 1, 9'd8, 32'h80 + i, 1, 1, 0, 9'd9, 32'h90 + i, 1, 0, 0);
`endif
        end

        // Locked p1 write burst of 12 against a waiting p0 read.
        do_reset();
        begin
            int k = 0;
            for (int i = 0; i < 13; i++) begin
                drive("burst", i != 0, 0, 9'd5, 0, 1, 1, 1, 9'(16 + k), 32'h100 + k,
                      i == 8, i != 8, 32'hAA);
                if (i != 8) k++;
            end
        end
        drive("burst_end", 1, 0, 9'd5, 0, 0, 0, 0, 9'd0, 0, 1, 0, 32'hAA);
        drive("idle1", 0, 0, 9'd0, 0, 0, 0, 0, 9'd0, 0, 0, 0, 0);

        // Alternating single-port reads, no bubbles.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive("alt_p0", 1, 0, 9'd1, 0, 0, 0, 0, 9'd0, 0, 1, 0, 32'h11);
            else            drive("alt_p1", 0, 0, 9'd0, 0, 1, 0, 0, 9'd2, 0, 0, 1, 32'h22);
        end
        drive("idle2", 0, 0, 9'd0, 0, 0, 0, 0, 9'd0, 0, 0, 0, 0);

        // Reset on the fourth cycle of a locked p1 read burst.
        drive("lrd0", 0, 0, 9'd0, 0, 1, 0, 1, 9'd1, 0, 0, 1, 32'h11);
        drive("lrd1", 1, 0, 9'd5, 0, 1, 0, 1, 9'd2, 0, 0, 1, 32'h22);
        drive("lrd2", 1, 0, 9'd5, 0, 1, 0, 1, 9'd1, 0, 0, 1, 32'h11);
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'd5;
        p1_req = 1'b1; p1_we = 1'b0; p1_lock = 1'b1; p1_addr = 9'd2;
        #1 reset = 1'b0;
        #1;
        check("midrst.p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("midrst.p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("midrst.p0_gnt", 32'(p0_gnt), 32'd1);
        check("midrst.p1_gnt", 32'(p1_gnt), 32'd0);
        @(negedge clk);
        #1;
        check("midrst2.p0_rvalid", 32'(p0_rvalid), 32'd0);
        check("midrst2.p1_rvalid", 32'(p1_rvalid), 32'd0);
        idle_inputs();
        reset = 1'b1;
        drive("post_rst", 1, 0, 9'd1, 0, 1, 0, 0, 9'd2, 0, 1, 0, 32'h11);
        drive("idle3", 0, 0, 9'd0, 0, 0, 0, 0, 9'd0, 0, 0, 0, 0);
        drive("idle4", 0, 0, 9'd0, 0, 0, 0, 0, 9'd0, 0, 0, 0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter MAX_BURST, default 8: maximum consecutive locked grants to port 1 while port 0 waits.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports p0_req, p0_we  input  1 each  core MEM-stage request and write-enable.
REQ-007 SHALL have ports p0_addr  input  ADDR_W, and p0_wdata  input  DATA_W.
REQ-008 SHALL have ports p1_req, p1_we, p1_lock  input  1 each  debug/loader request, write-enable and burst lock.
REQ-009 SHALL have ports p1_addr  input  ADDR_W, and p1_wdata  input  DATA_W.
REQ-010 SHALL have ports p0_gnt, p1_gnt  output  1 each  same-cycle grant.
REQ-011 SHALL have ports p0_rvalid, p1_rvalid  output  1 each  read data valid, one cycle after a granted read.
REQ-012 SHALL have port rdata  output  DATA_W  mem_rdata passed through, meaningful only when the matching rvalid is high.
REQ-013 SHALL have port core_stall  output  1  equal to p0_req AND NOT p0_gnt.
REQ-014 SHALL have ports mem_en, mem_we  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W.
REQ-015 SHALL have port mem_rdata  input  DATA_W  synchronous-read memory output, one cycle of latency.

Function
REQ-016 SHALL grant at most one port per cycle; the grants and mem_* outputs are combinational from state and requests.
REQ-017 SHALL drive mem_en = p0_gnt OR p1_gnt, and SHALL mux mem_we, mem_addr and mem_wdata from the granted port; all are 0 when no port is granted.
REQ-018 SHALL implement FSM states IDLE and LOCK1.
REQ-019 In IDLE, if only one port requests, that port SHALL be granted.
REQ-020 In IDLE with both ports requesting, the winner SHALL follow the REQ-029 policy.
REQ-021 IDLE -> LOCK1 SHALL occur when p1 is granted with p1_lock=1; the burst counter is loaded with 1.
REQ-022 In LOCK1, p1 SHALL be granted while p1_req=1, and the burst counter SHALL increment per grant, saturating at MAX_BURST.
REQ-023 In LOCK1, if the counter equals MAX_BURST and p0_req=1, p0 SHALL be granted for that cycle, the counter SHALL clear, and the state SHALL stay LOCK1 if p1_lock=1.
REQ-024 LOCK1 -> IDLE SHALL occur when p1_lock=0 or p1_req=0; the counter clears and the current cycle is arbitrated as in IDLE.
REQ-025 A 1-bit owner register SHALL capture the granted port on every granted read (mem_we=0).
REQ-026 Exactly one rvalid SHALL pulse the next cycle; writes produce no rvalid.
REQ-027 Back-to-back reads from alternating ports SHALL each return their data in order, with no bubble.

Reset
REQ-028 While reset=0: state=IDLE, burst counter=0, rvalid outputs=0, owner=0, round-robin pointer = last-granted p1 (so p0 wins first). Combinational outputs follow requests from IDLE. A reset asserted mid-burst SHALL abandon the burst, and any pending rvalid SHALL be dropped.

Configuration
REQ-029 With DMEM_ARB_RR_EN defined, IDLE contention SHALL be round-robin: the port not granted last wins, and the pointer updates on every grant. Without the macro, p0 SHALL always win IDLE contention and no pointer SHALL exist. LOCK1 behaviour is identical in both builds.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the state enum (IDLE, LOCK1), the port-id typedef, and the default ADDR_W/DATA_W constants.
REQ-031 A combinational sub-module dmem_arb_pick SHALL compute the IDLE winner from the requests and the pointer.

Verification
REQ-032 Reset, then p0 read addr 5 with mem word 5=0x0000_00AA -> p0_gnt same cycle, next cycle p0_rvalid=1 and rdata=0xAA.
REQ-033 p0 and p1 both request every cycle, RR build -> grants alternate p0,p1,p0,p1; fixed build -> p0 always wins and core_stall=0.
REQ-034 p1 locked write burst of 12 with p0_req held -> p1 granted 8 cycles, p0 granted once, then p1 granted 4 more; core_stall=1 on all other cycles.
REQ-035 Alternating reads p0 addr 1, p1 addr 2 (words 0x11/0x22) -> p0_rvalid then p1_rvalid on consecutive cycles with the matching data, and no cross-delivery.
REQ-036 reset asserted on burst cycle 3 -> all rvalid=0 and state IDLE; after release, the first contention is won by p0.
